data_memory: RTL and testbench
==============================

# data_memory

Byte-addressable, dual-port, little-endian data memory shared by the IOAC/variable-manager bus (system port) and an external client/loader port (client port). Each port has its own write-data, address, 2-bit write-size and 2-bit read-size controls. Writes are synchronous and reads are combinational. Used as the variable store that the IOAC scans by name and type.

## Interface
Parameters:
- ADDR_BITS, 16, byte-address bits actually decoded; depth = 2^ADDR_BITS bytes.

Ports:
- Clk  in  1  system clock; all writes on rising edge.
- Rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- MemWriteBus  in  32  system-port write data.
- MemAddrBus  in  32  system-port byte address.
- ClientMemWrite  in  32  client-port write data.
- ClientMemAddr  in  32  client-port byte address.
- WDMB  in  2  system-port write size.
- RDMB  in  2  system-port read size.
- CWDM  in  2  client-port write size.
- CRDM  in  2  client-port read size.
- MemReadBus  out  32  system-port read data.
- ClientReadData  out  32  client-port read data.

## Operation
- Size code for all four size inputs:
  - 0 = no access.
  - 1 = byte (data[7:0]).
  - 2 = halfword (data[15:0]).
  - 3 = word (data[31:0]).
- Address decode:
  - Only addr[ADDR_BITS-1:0] is used; upper bits are ignored.
  - No alignment requirement; any address is legal for any size.
- Little-endian layout: byte k of a multi-byte access (k=0 is the LSB) goes to address (A+k) mod depth. Accesses wrap from the top byte to address 0.
- Write:
  - On a rising edge, each port with non-zero write size stores its 1/2/4 low-order data bytes.
  - Unused upper data bits are ignored.
- Simultaneous writes:
  - Both ports may write in the same cycle.
  - Where they touch the same byte, the system port (MemWriteBus) wins.
  - Non-overlapping bytes from both ports are all written.
- Read:
  - Each read output is a pure combinational function of its port's address, read size and current memory contents.
  - Size 1 and size 2 results are zero-extended.
  - Size 0 drives 32'h0.
- Read-during-write (same or other port): the read returns the old contents until the write edge, and the new contents afterwards.
- Reset:
  - While Rst=1 at a rising edge, every byte is cleared to 8'h00 and all writes that cycle are suppressed. Reset wins over a simultaneous write.
  - Outputs then follow the cleared contents: 0 for any read.
- Write size, read size and address are independent per port; a port may read and write in the same cycle.

## Timing
- Write latency: 1 edge. Data is visible on either read port combinationally right after the edge.
- Read latency: 0 cycles, combinational from address and size.
- No handshake and no busy state. Every access completes in its cycle.
- Reset value of outputs: 32'h0 after reset for any read size (memory cleared). With size 0 the outputs are always 0.
- No X propagation from unwritten bytes is required: reset defines all contents.

## Test plan
- Reset then client byte writes: 0x01→0x8000, 0x61→0x8001, 0x62→0x8002, 0x63→0x8003, 0x20→0x8004 (CWDM=1). Then client word read at 0x8000 (CRDM=3) → 32'h63626101.
- Unaligned word write: ClientMemWrite=32'h1234ABCD at 0x8015, CWDM=3.
  - Byte reads at 0x8015..0x8018 → CD, AB, 34, 12.
  - System halfword read at 0x8016 (RDMB=2) → 32'h000034AB.
- Overlap and overwrite: word 32'h5 at 0x8005, then word 0 at 0x8009, then byte 0x02 at 0x800A. Word read at 0x8005 → 32'h00000005; byte read at 0x800A → 32'h02.
- Simultaneous same-address writes: system writes byte 0xAA and client writes byte 0x55, both to 0x100 in the same cycle → read at 0x100 gives 0xAA. Same cycle with system at 0x100 and client at 0x101 → both bytes stored.
- Wrap-around: word 32'hDEADBEEF written at address 0xFFFE (ADDR_BITS=16).
  - Byte reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001 → EF, BE, AD, DE.
  - Same write to address 0x1FFFE aliases identically.
- Reset mid-operation: assert Rst in the same cycle as a CWDM=3 write to 0x8000 → the write is suppressed. Any read afterwards → 0. RDMB=0 always gives 0 regardless of contents.

Source files
------------

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable dual-port little-endian data memory
// Synchronous byte writes from the system and client ports, combinational zero-extended reads.
module data_memory #(
  parameter int ADDR_BITS = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] MemWriteBus,
  input  logic [31:0] MemAddrBus,
  input  logic [31:0] ClientMemWrite,
  input  logic [31:0] ClientMemAddr,
  input  logic [1:0]  WDMB,
  input  logic [1:0]  RDMB,
  input  logic [1:0]  CWDM,
  input  logic [1:0]  CRDM,
  output logic [31:0] MemReadBus,
  output logic [31:0] ClientReadData
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           r_mem [DEPTH];
  logic [ADDR_BITS-1:0] w_sys_addr;
  logic [ADDR_BITS-1:0] w_cli_addr;

  assign w_sys_addr = MemAddrBus[ADDR_BITS-1:0];
  assign w_cli_addr = ClientMemAddr[ADDR_BITS-1:0];

  function automatic int size_bytes(input logic [1:0] size);
    case (size)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  // Client bytes are scheduled first so a system write to the same byte overrides it.
  // The address adder is ADDR_BITS wide, so multi-byte accesses wrap to 0 for free.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k < size_bytes(CWDM)) begin
          r_mem[w_cli_addr + ADDR_BITS'(k)] <= ClientMemWrite[8*k +: 8];
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (k < size_bytes(WDMB)) begin
          r_mem[w_sys_addr + ADDR_BITS'(k)] <= MemWriteBus[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    MemReadBus     = 32'h0;
    ClientReadData = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k < size_bytes(RDMB)) begin
        MemReadBus[8*k +: 8] = r_mem[w_sys_addr + ADDR_BITS'(k)];
      end
      if (k < size_bytes(CRDM)) begin
        ClientReadData[8*k +: 8] = r_mem[w_cli_addr + ADDR_BITS'(k)];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard testbench for data_memory
// Each scenario queues its expected read values as it drives stimulus and pops them on readback.
module tb_data_memory;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] MemWriteBus = '0;
  logic [31:0] MemAddrBus = '0;
  logic [31:0] ClientMemWrite = '0;
  logic [31:0] ClientMemAddr = '0;
  logic [1:0]  WDMB = '0;
  logic [1:0]  RDMB = '0;
  logic [1:0]  CWDM = '0;
  logic [1:0]  CRDM = '0;
  logic [31:0] MemReadBus;
  logic [31:0] ClientReadData;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  data_memory #(.ADDR_BITS(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemWriteBus(MemWriteBus), .MemAddrBus(MemAddrBus),
    .ClientMemWrite(ClientMemWrite), .ClientMemAddr(ClientMemAddr),
    .WDMB(WDMB), .RDMB(RDMB), .CWDM(CWDM), .CRDM(CRDM),
    .MemReadBus(MemReadBus), .ClientReadData(ClientReadData)
  );

  always #5 Clk = ~Clk;

  task automatic wr(input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] ssz,
                    input logic [31:0] ca, input logic [31:0] cd, input logic [1:0] csz);
    @(negedge Clk);
    MemAddrBus = sa; MemWriteBus = sd; WDMB = ssz;
    ClientMemAddr = ca; ClientMemWrite = cd; CWDM = csz;
    @(posedge Clk);
    #1;
    WDMB = 2'd0; CWDM = 2'd0;
  endtask

  task automatic rd(input bit sys, input logic [31:0] a, input logic [1:0] sz, output logic [31:0] d);
    if (sys) begin
      MemAddrBus = a; RDMB = sz; #1; d = MemReadBus; RDMB = 2'd0;
    end else begin
      ClientMemAddr = a; CRDM = sz; #1; d = ClientReadData; CRDM = 2'd0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    logic [31:0] addrs [4] = '{32'h0, 32'h8000, 32'hFFFE, 32'h1234};
    Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{"reset_sys", 32'h0});
      rd(1'b1, addrs[i], 2'd3, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s @%h: got %h expected %h", e.name, addrs[i], got, e.val); end
      exp_q.push_back('{"reset_cli", 32'h0});
      rd(1'b0, addrs[i], 2'd3, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s @%h: got %h expected %h", e.name, addrs[i], got, e.val); end
    end
  endtask

  task automatic test_byte_writes();
    logic [31:0] got;
    logic [7:0] data [5] = '{8'h01, 8'h61, 8'h62, 8'h63, 8'h20};
    for (int i = 0; i < 5; i++) wr(32'h0, 32'h0, 2'd0, 32'h8000 + i, {24'hFFFFFF, data[i]}, 2'd1);
    exp_q.push_back('{"byte_word_cli", 32'h63626101});
    exp_q.push_back('{"byte_word_sys", 32'h63626101});
    exp_q.push_back('{"byte_half_8004", 32'h00000020});
    rd(1'b0, 32'h8000, 2'd3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    rd(1'b1, 32'h8000, 2'd3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    rd(1'b1, 32'h8004, 2'd2, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_unaligned();
    logic [31:0] got;
    logic [7:0] bytes_exp [4] = '{8'hCD, 8'hAB, 8'h34, 8'h12};
    wr(32'h0, 32'h0, 2'd0, 32'h8015, 32'h1234ABCD, 2'd3);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{"unaligned_byte", {24'h0, bytes_exp[i]}});
      rd(1'b0, 32'h8015 + i, 2'd1, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s %0d: got %h expected %h", e.name, i, got, e.val); end
    end
    exp_q.push_back('{"unaligned_half_sys", 32'h000034AB});
    rd(1'b1, 32'h8016, 2'd2, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_overlap();
    logic [31:0] got;
    wr(32'h0, 32'h0, 2'd0, 32'h8005, 32'h00000005, 2'd3);
    wr(32'h0, 32'h0, 2'd0, 32'h8009, 32'h00000000, 2'd3);
    wr(32'h0, 32'h0, 2'd0, 32'h800A, 32'hABCDEF02, 2'd1);
    exp_q.push_back('{"overlap_word_8005", 32'h00000005});
    exp_q.push_back('{"overlap_byte_800A", 32'h00000002});
    exp_q.push_back('{"overlap_word_8009", 32'h00000200});
    rd(1'b0, 32'h8005, 2'd3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    rd(1'b0, 32'h800A, 2'd1, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    rd(1'b1, 32'h8009, 2'd3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] got;
    wr(32'h100, 32'h000000AA, 2'd1, 32'h100, 32'h00000055, 2'd1);
    exp_q.push_back('{"simul_same_byte", 32'h000000AA});
    rd(1'b0, 32'h100, 2'd1, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    wr(32'h100, 32'h00000011, 2'd1, 32'h101, 32'h00000022, 2'd1);
    exp_q.push_back('{"simul_adjacent", 32'h00002211});
    rd(1'b1, 32'h100, 2'd2, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    wr(32'h301, 32'h00000099, 2'd1, 32'h300, 32'h44332211, 2'd3);
    exp_q.push_back('{"simul_partial", 32'h44339911});
    rd(1'b0, 32'h300, 2'd3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_wrap();
    logic [31:0] got;
    logic [31:0] addrs [4] = '{32'hFFFE, 32'hFFFF, 32'h0000, 32'h0001};
    logic [7:0]  bexp  [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr(32'h0, 32'h0, 2'd0, 32'hFFFE, 32'hDEADBEEF, 2'd3);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{"wrap_byte", {24'h0, bexp[i]}});
      rd(1'b0, addrs[i], 2'd1, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s @%h: got %h expected %h", e.name, addrs[i], got, e.val); end
    end
    wr(32'h1FFFE, 32'hCAFEF00D, 2'd3, 32'h0, 32'h0, 2'd0);
    exp_q.push_back('{"alias_word", 32'hCAFEF00D});
    exp_q.push_back('{"alias_upper_read", 32'h000000FE});
    rd(1'b0, 32'hFFFE, 2'd3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    rd(1'b1, 32'h30000, 2'd1, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] got;
    wr(32'h0, 32'h0, 2'd0, 32'h600, 32'h00000011, 2'd1);
    exp_q.push_back('{"rdw_old", 32'h00000011});
    exp_q.push_back('{"rdw_new", 32'h000000A5});
    @(negedge Clk);
    ClientMemAddr = 32'h600; ClientMemWrite = 32'h000000A5; CWDM = 2'd1;
    MemAddrBus = 32'h600; RDMB = 2'd1;
    #1 got = MemReadBus;
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    @(posedge Clk);
    #1 got = MemReadBus;
    CWDM = 2'd0; RDMB = 2'd0;
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic [31:0] addrs [3] = '{32'h8000, 32'h100, 32'hFFFE};
    @(negedge Clk);
    Rst = 1'b1;
    ClientMemAddr = 32'h8000; ClientMemWrite = 32'hFFFFFFFF; CWDM = 2'd3;
    MemAddrBus = 32'h100; MemWriteBus = 32'hFFFFFFFF; WDMB = 2'd3;
    @(posedge Clk);
    #1 Rst = 1'b0; CWDM = 2'd0; WDMB = 2'd0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{"reset_mid", 32'h0});
      rd(i[0], addrs[i], 2'd3, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s @%h: got %h expected %h", e.name, addrs[i], got, e.val); end
    end
    wr(32'h700, 32'h12345678, 2'd3, 32'h0, 32'h0, 2'd0);
    exp_q.push_back('{"size0_sys", 32'h0});
    exp_q.push_back('{"size0_cli", 32'h0});
    exp_q.push_back('{"size3_after", 32'h12345678});
    rd(1'b1, 32'h700, 2'd0, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    rd(1'b0, 32'h700, 2'd0, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
    rd(1'b1, 32'h700, 2'd3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e.val) begin errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val); end
  endtask

  initial begin
    test_reset();
    test_byte_writes();
    test_unaligned();
    test_overlap();
    test_simultaneous();
    test_wrap();
    test_read_during_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
